barrel_thread_fetch: RTL and testbench

Per-thread program-counter file and round-robin thread issuer for the barrel-threaded RV32I core; sits directly upstream of the fetch pipeline stages and drives the instruction-memory address each cycle. Each hardware thread gets one fixed issue slot in rotation. A thread has at most one instruction in flight, and its next PC is returned from the execute/writeback stage. With `NUM_THREADS` ≥ `NUM_PIPE_STAGES`, every enabled slot issues; otherwise, slots whose thread is still in flight issue bubbles.

---
 rtl/barrel_thread_fetch.sv | 83 ++++++++
 tb/tb_barrel_thread_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_thread_fetch.sv
// rtl/barrel_thread_fetch.sv - per-thread PC file and round-robin barrel thread issuer
module barrel_thread_fetch #(
    parameter int                NUM_THREADS  = 16,
    parameter int                DWIDTH       = 32,
    parameter int                ADDR_WIDTH   = 10,
    parameter logic [DWIDTH-1:0] STARTUP_ADDR = '0,
    localparam int               TID_W        = $clog2(NUM_THREADS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_THREADS-1:0] thread_en_i,
    input  logic                   wb_valid_i,
    input  logic [TID_W-1:0]       wb_thread_i,
    input  logic [DWIDTH-1:0]      wb_pc_i,
    output logic                   if_valid_o,
    output logic [TID_W-1:0]       if_thread_o,
    output logic [DWIDTH-1:0]      if_pc_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    output logic [NUM_THREADS-1:0] inflight_o,
    output logic                   misalign_err_o,
    output logic                   wb_err_o
);

    logic [TID_W-1:0]       slot;
    logic [DWIDTH-1:0]      pc [NUM_THREADS];
    logic [NUM_THREADS-1:0] inflight;
    logic [NUM_THREADS-1:0] inflight_next;
    logic [DWIDTH-1:0]      wb_aligned;
    logic [DWIDTH-1:0]      issue_pc;
    logic                   hit;
    logic                   can_issue;

    assign wb_aligned = {wb_pc_i[DWIDTH-1:2], 2'b00};
    assign hit        = wb_valid_i && (wb_thread_i == slot);
    assign can_issue  = thread_en_i[slot] && (!inflight[slot] || hit);
    // A returning PC for the current slot is forwarded straight to issue.
    assign issue_pc   = (can_issue && hit) ? wb_aligned : pc[slot];
    assign inflight_o = inflight;

    // Clear on writeback first so a same-cycle re-issue keeps the flag set.
    always_comb begin
        inflight_next = inflight;
        if (wb_valid_i) begin
            inflight_next[wb_thread_i] = 1'b0;
        end
        if (can_issue) begin
            inflight_next[slot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot           <= '0;
            inflight       <= '0;
            if_valid_o     <= 1'b0;
            if_thread_o    <= '0;
            if_pc_o        <= '0;
            imem_addr_o    <= '0;
            misalign_err_o <= 1'b0;
            wb_err_o       <= 1'b0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc[i] <= STARTUP_ADDR;
            end
        end else begin
            slot        <= slot + 1'b1;
            inflight    <= inflight_next;
            if_valid_o  <= can_issue;
            if_thread_o <= slot;
            if_pc_o     <= issue_pc;
            imem_addr_o <= issue_pc[ADDR_WIDTH+1:2];
            if (wb_valid_i) begin
                pc[wb_thread_i] <= wb_aligned;
                if (wb_pc_i[1:0] != 2'b00) begin
                    misalign_err_o <= 1'b1;
                end
                if (!inflight[wb_thread_i]) begin
                    wb_err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_barrel_thread_fetch.sv
// tb/tb_barrel_thread_fetch.sv - scoreboard bench for barrel_thread_fetch
module tb_barrel_thread_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] thread_en_i;
    logic        wb_valid_i;
    logic [3:0]  wb_thread_i;
    logic [31:0] wb_pc_i;
    logic        if_valid_o;
    logic [3:0]  if_thread_o;
    logic [31:0] if_pc_o;
    logic [9:0]  imem_addr_o;
    logic [15:0] inflight_o;
    logic        misalign_err_o;
    logic        wb_err_o;

    barrel_thread_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .thread_en_i    (thread_en_i),
        .wb_valid_i     (wb_valid_i),
        .wb_thread_i    (wb_thread_i),
        .wb_pc_i        (wb_pc_i),
        .if_valid_o     (if_valid_o),
        .if_thread_o    (if_thread_o),
        .if_pc_o        (if_pc_o),
        .imem_addr_o    (imem_addr_o),
        .inflight_o     (inflight_o),
        .misalign_err_o (misalign_err_o),
        .wb_err_o       (wb_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [3:0]  th;
        logic [31:0] pc;
        logic [9:0]  ad;
        logic [15:0] inf;
        logic        me;
        logic        we;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [3:0]  m_slot;
    logic [31:0] m_pc[16];
    logic [15:0] m_inf;
    logic        m_me;
    logic        m_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural reference of one cycle; expected outputs queued, then compared after the edge.
    task automatic step();
        exp_t        e;
        exp_t        got;
        logic [3:0]  t;
        logic        hit;
        logic        can;
        logic [31:0] ipc;
        logic [15:0] ni;
        if (reset) begin
            m_slot = '0;
            m_inf  = '0;
            m_me   = 1'b0;
            m_we   = 1'b0;
            for (int i = 0; i < 16; i++) m_pc[i] = 32'h0;
            e = '0;
        end else begin
            t   = m_slot;
            hit = wb_valid_i && (wb_thread_i == t);
            can = thread_en_i[t] && (!m_inf[t] || hit);
            ipc = (can && hit) ? {wb_pc_i[31:2], 2'b00} : m_pc[t];
            ni  = m_inf;
            if (wb_valid_i) begin
                if (!m_inf[wb_thread_i]) m_we = 1'b1;
                else ni[wb_thread_i] = 1'b0;
                if (wb_pc_i[1:0] != 2'b00) m_me = 1'b1;
                m_pc[wb_thread_i] = {wb_pc_i[31:2], 2'b00};
            end
            if (can) ni[t] = 1'b1;
            m_inf  = ni;
            m_slot = m_slot + 4'd1;
            e = '{v: can, th: t, pc: ipc, ad: ipc[11:2], inf: ni, me: m_me, we: m_we};
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("sb_valid",    {31'b0, if_valid_o},     {31'b0, got.v});
        chk("sb_thread",   {28'b0, if_thread_o},    {28'b0, got.th});
        chk("sb_pc",       if_pc_o,                 got.pc);
        chk("sb_imem",     {22'b0, imem_addr_o},    {22'b0, got.ad});
        chk("sb_inflight", {16'b0, inflight_o},     {16'b0, got.inf});
        chk("sb_misalign", {31'b0, misalign_err_o}, {31'b0, got.me});
        chk("sb_wb_err",   {31'b0, wb_err_o},       {31'b0, got.we});
    endtask

    task automatic run_to_slot(input logic [3:0] s);
        for (int n = 0; n < 32 && m_slot != s; n++) step();
    endtask

    task automatic wb(input logic [3:0] th, input logic [31:0] pcv);
        wb_valid_i  = 1'b1;
        wb_thread_i = th;
        wb_pc_i     = pcv;
        step();
        wb_valid_i  = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        thread_en_i = 16'hFFFF;
        wb_valid_i  = 1'b0;
        wb_thread_i = '0;
        wb_pc_i     = '0;
        step();
        chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("rst_pc", if_pc_o, 32'd0);
        chk("rst_inflight", {16'b0, inflight_o}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step();
            chk("rot1_valid", {31'b0, if_valid_o}, 32'd1);
            chk("rot1_thread", {28'b0, if_thread_o}, i);
            chk("rot1_pc", if_pc_o, 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            chk("rot2_bubble", {31'b0, if_valid_o}, 32'd0);
        end
        chk("rot2_inflight", {16'b0, inflight_o}, 32'h0000FFFF);

        // return thread 3 three slots ahead of its turn
        wb(4'd3, 32'h4);
        run_to_slot(4'd3);
        step();
        chk("t3_valid", {31'b0, if_valid_o}, 32'd1);
        chk("t3_pc", if_pc_o, 32'h4);
        chk("t3_imem", {22'b0, imem_addr_o}, 32'd1);

        run_to_slot(4'd5);
        wb(4'd5, 32'h100);
        chk("byp_valid", {31'b0, if_valid_o}, 32'd1);
        chk("byp_thread", {28'b0, if_thread_o}, 32'd5);
        chk("byp_pc", if_pc_o, 32'h100);
        chk("byp_imem", {22'b0, imem_addr_o}, 32'h40);
        chk("byp_inflight5", {31'b0, inflight_o[5]}, 32'd1);

        wb(4'd2, 32'h102);
        chk("mis_flag", {31'b0, misalign_err_o}, 32'd1);
        run_to_slot(4'd2);
        step();
        chk("mis_valid", {31'b0, if_valid_o}, 32'd1);
        chk("mis_pc", if_pc_o, 32'h100);

        thread_en_i[7] = 1'b0;
        wb(4'd7, 32'h10);
        chk("spur_pre_err", {31'b0, wb_err_o}, 32'd0);
        chk("spur_pre_inf7", {31'b0, inflight_o[7]}, 32'd0);
        wb(4'd7, 32'h20);
        chk("spur_err", {31'b0, wb_err_o}, 32'd1);
        thread_en_i[7] = 1'b1;
        run_to_slot(4'd7);
        step();
        chk("spur_valid", {31'b0, if_valid_o}, 32'd1);
        chk("spur_pc", if_pc_o, 32'h20);

        thread_en_i[4] = 1'b0;
        wb(4'd4, 32'h8);
        run_to_slot(4'd4);
        step();
        chk("dis_bubble", {31'b0, if_valid_o}, 32'd0);
        chk("dis_pc", if_pc_o, 32'h8);
        chk("dis_inf4", {31'b0, inflight_o[4]}, 32'd0);
        run_to_slot(4'd4);
        step();
        chk("dis_bubble2", {31'b0, if_valid_o}, 32'd0);
        thread_en_i[4] = 1'b1;
        run_to_slot(4'd4);
        step();
        chk("ena_valid", {31'b0, if_valid_o}, 32'd1);
        chk("ena_pc", if_pc_o, 32'h8);
        chk("mis_sticky", {31'b0, misalign_err_o}, 32'd1);
        chk("err_sticky", {31'b0, wb_err_o}, 32'd1);

        // mid-stream reset with a writeback that must be dropped
        step();
        reset       = 1'b1;
        wb_valid_i  = 1'b1;
        wb_thread_i = 4'd0;
        wb_pc_i     = 32'h40;
        step();
        chk("mrst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("mrst_thread", {28'b0, if_thread_o}, 32'd0);
        chk("mrst_pc", if_pc_o, 32'd0);
        chk("mrst_imem", {22'b0, imem_addr_o}, 32'd0);
        chk("mrst_inflight", {16'b0, inflight_o}, 32'd0);
        chk("mrst_mis", {31'b0, misalign_err_o}, 32'd0);
        chk("mrst_err", {31'b0, wb_err_o}, 32'd0);
        reset      = 1'b0;
        wb_valid_i = 1'b0;
        step();
        chk("restart_valid", {31'b0, if_valid_o}, 32'd1);
        chk("restart_thread", {28'b0, if_thread_o}, 32'd0);
        chk("restart_pc", if_pc_o, 32'd0);
        step();
        chk("restart_thread1", {28'b0, if_thread_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
